// File: rtl/magia_print_responder.sv
`timescale 1ns/1ps
// magia_print_responder
// AXI4 slave for the per-tile print window at BASE_ADDR.
//   +0x4 : stdio byte write, queued with its AXI ID on the char stream;
//          read returns the FIFO free count.
//   +0x0 : stderr byte write, latches err_code_o/err_valid_o;
//          read returns {0, err_code_o}. Only when MAGIA_PRINT_RSP_STDERR_EN
//          is defined; otherwise SLVERR and err outputs tied to 0.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   aw_*/w_*/b_* : single-beat AXI write, one transaction in flight
//   ar_*/r_*     : single-beat AXI read, registered R beat
//   char_*       : character stream (valid/ready), eol flags 0x0A
//   err_code_o, err_valid_o : last stderr byte, sticky flag
module magia_print_responder #(
   parameter int unsigned       ID_W       = 4,
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'hFFFF_0000,
   parameter int unsigned       FIFO_DEPTH = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                aw_valid_i,
   output logic                aw_ready_o,
   input  logic [ADDR_W-1:0]   aw_addr_i,
   input  logic [ID_W-1:0]     aw_id_i,
   input  logic [7:0]          aw_len_i,
   input  logic                w_valid_i,
   output logic                w_ready_o,
   input  logic [DATA_W-1:0]   w_data_i,
   input  logic [DATA_W/8-1:0] w_strb_i,
   input  logic                w_last_i,
   output logic                b_valid_o,
   input  logic                b_ready_i,
   output logic [ID_W-1:0]     b_id_o,
   output logic [1:0]          b_resp_o,
   input  logic                ar_valid_i,
   output logic                ar_ready_o,
   input  logic [ADDR_W-1:0]   ar_addr_i,
   input  logic [ID_W-1:0]     ar_id_i,
   output logic                r_valid_o,
   input  logic                r_ready_i,
   output logic [ID_W-1:0]     r_id_o,
   output logic [DATA_W-1:0]   r_data_o,
   output logic [1:0]          r_resp_o,
   output logic                r_last_o,
   output logic                char_valid_o,
   input  logic                char_ready_i,
   output logic [7:0]          char_data_o,
   output logic [ID_W-1:0]     char_id_o,
   output logic                char_eol_o,
   output logic [7:0]          err_code_o,
   output logic                err_valid_o
);

   localparam int unsigned       PtrW     = $clog2(FIFO_DEPTH);
   localparam int unsigned       CntW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW-1:0]   DepthCnt = CntW'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] AddrErr  = BASE_ADDR;
   localparam logic [ADDR_W-1:0] AddrChr  = BASE_ADDR + ADDR_W'(4);
   localparam logic [1:0]        RespOkay = 2'b00;
   localparam logic [1:0]        RespSlv  = 2'b10;

   typedef enum logic [1:0] {StIdle, StWrite, StResp} wr_state_e;

   wr_state_e         state_q, state_d;
   logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [ID_W-1:0]   aw_id_q;
   logic              len_bad_q;
   logic [7:0]        w_byte_q;
   logic              w_ok_q;
   logic [1:0]        b_resp_q, b_resp_d;
   logic              push, pop;

   logic [7:0]      mem_data [FIFO_DEPTH];
   logic [ID_W-1:0] mem_id   [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;

   logic              r_valid_q;
   logic [ID_W-1:0]   r_id_q;
   logic [DATA_W-1:0] r_data_q, rd_data;
   logic [1:0]        r_resp_q, rd_resp;

   // Bits the window never looks at.
   logic unused_bits;
   assign unused_bits = ^{w_data_i[DATA_W-1:8], w_strb_i[DATA_W/8-1:1]};

   // Readies are gated by reset so they stay low while rst_i is held.
   assign aw_ready_o = !rst_i && (state_q == StIdle) && !aw_got_q;
   assign w_ready_o  = !rst_i && (state_q == StIdle) && !w_got_q;
   assign b_valid_o  = (state_q == StResp);
   assign b_id_o     = aw_id_q;
   assign b_resp_o   = b_resp_q;

`ifdef MAGIA_PRINT_RSP_STDERR_EN
   logic [7:0] err_code_q;
   logic       err_valid_q;
   logic       err_we;
   assign err_code_o  = err_code_q;
   assign err_valid_o = err_valid_q;
`else
   assign err_code_o  = 8'h00;
   assign err_valid_o = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      b_resp_d = b_resp_q;
      push     = 1'b0;
`ifdef MAGIA_PRINT_RSP_STDERR_EN
      err_we   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (aw_valid_i && aw_ready_o) aw_got_d = 1'b1;
            if (w_valid_i && w_ready_o)   w_got_d  = 1'b1;
            if (aw_got_d && w_got_d)      state_d  = StWrite;
         end
         StWrite: begin
            if (len_bad_q || !w_ok_q) begin
               b_resp_d = RespSlv;
               state_d  = StResp;
            end else if (aw_addr_q == AddrChr) begin
               // Full: hold here and retry; a same-cycle pop does not help.
               if (count_q < DepthCnt) begin
                  push     = 1'b1;
                  b_resp_d = RespOkay;
                  state_d  = StResp;
               end
`ifdef MAGIA_PRINT_RSP_STDERR_EN
            end else if (aw_addr_q == AddrErr) begin
               err_we   = 1'b1;
               b_resp_d = RespOkay;
               state_d  = StResp;
`endif
            end else begin
               b_resp_d = RespSlv;
               state_d  = StResp;
            end
         end
         StResp: begin
            if (b_ready_i) begin
               state_d  = StIdle;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign pop = (count_q != '0) && char_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         aw_addr_q <= '0;
         aw_id_q   <= '0;
         len_bad_q <= 1'b0;
         w_byte_q  <= 8'h00;
         w_ok_q    <= 1'b0;
         b_resp_q  <= 2'b00;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q  <= state_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
         b_resp_q <= b_resp_d;
         if (aw_valid_i && aw_ready_o) begin
            aw_addr_q <= aw_addr_i;
            aw_id_q   <= aw_id_i;
            len_bad_q <= (aw_len_i != 8'd0);
         end
         if (w_valid_i && w_ready_o) begin
            w_byte_q <= w_data_i[7:0];
            w_ok_q   <= w_last_i && w_strb_i[0];
         end
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data[wr_ptr_q] <= w_byte_q;
         mem_id[wr_ptr_q]   <= aw_id_q;
      end
   end

   assign char_valid_o = (count_q != '0);
   assign char_data_o  = char_valid_o ? mem_data[rd_ptr_q] : 8'h00;
   assign char_id_o    = char_valid_o ? mem_id[rd_ptr_q] : '0;
   assign char_eol_o   = char_valid_o && (char_data_o == 8'h0A);

`ifdef MAGIA_PRINT_RSP_STDERR_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_code_q  <= 8'h00;
         err_valid_q <= 1'b0;
      end else if (err_we) begin
         err_code_q  <= w_byte_q;
         err_valid_q <= 1'b1;
      end
   end
`endif

   // Read decode from the live AR address; the beat is registered below.
   always_comb begin
      rd_data = '0;
      rd_resp = RespSlv;
      if (ar_addr_i == AddrChr) begin
         rd_data = DATA_W'(DepthCnt - count_q);
         rd_resp = RespOkay;
`ifdef MAGIA_PRINT_RSP_STDERR_EN
      end else if (ar_addr_i == AddrErr) begin
         rd_data = DATA_W'(err_code_q);
         rd_resp = RespOkay;
`endif
      end
   end

   assign ar_ready_o = !rst_i && !r_valid_q;
   assign r_valid_o  = r_valid_q;
   assign r_id_o     = r_id_q;
   assign r_data_o   = r_data_q;
   assign r_resp_o   = r_resp_q;
   assign r_last_o   = r_valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid_q <= 1'b0;
         r_id_q    <= '0;
         r_data_q  <= '0;
         r_resp_q  <= 2'b00;
      end else if (ar_valid_i && ar_ready_o) begin
         r_valid_q <= 1'b1;
         r_id_q    <= ar_id_i;
         r_data_q  <= rd_data;
         r_resp_q  <= rd_resp;
      end else if (r_ready_i) begin
         r_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_magia_print_responder.sv
`timescale 1ns/1ps
// Directed self-checking bench for magia_print_responder (default parameters).
module tb_magia_print_responder;

   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk, rst;
   logic        aw_valid, aw_ready;
   logic [31:0] aw_addr;
   logic [3:0]  aw_id;
   logic [7:0]  aw_len;
   logic        w_valid, w_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        ar_valid, ar_ready;
   logic [31:0] ar_addr;
   logic [3:0]  ar_id;
   logic        r_valid, r_ready;
   logic [3:0]  r_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        char_valid, char_ready;
   logic [7:0]  char_data;
   logic [3:0]  char_id;
   logic        char_eol;
   logic [7:0]  err_code;
   logic        err_valid;

   int checks = 0;
   int failures = 0;

   magia_print_responder dut (
      .clk_i(clk), .rst_i(rst),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr),
      .aw_id_i(aw_id), .aw_len_i(aw_len),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
      .w_strb_i(w_strb), .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_id_i(ar_id),
      .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
      .r_resp_o(r_resp), .r_last_o(r_last),
      .char_valid_o(char_valid), .char_ready_i(char_ready), .char_data_o(char_data),
      .char_id_o(char_id), .char_eol_o(char_eol),
      .err_code_o(err_code), .err_valid_o(err_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns once the later of AW/W has handshaken; caller is then in N+1.
   task automatic send_wr(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] data,
                          input logic [3:0] strb, input logic [7:0] len, input logic last,
                          output bit ok);
      bit aw_done, w_done, aw_hs, w_hs;
      aw_done = 0; w_done = 0; ok = 0;
      aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len;
      w_valid = 1'b1; w_data = {24'h0, data}; w_strb = strb; w_last = last;
      for (int i = 0; i < 20; i++) begin
         aw_hs = aw_valid && aw_ready;
         w_hs  = w_valid && w_ready;
         tick();
         if (aw_hs) begin aw_done = 1; aw_valid = 1'b0; end
         if (w_hs)  begin w_done = 1;  w_valid = 1'b0; end
         if (aw_done && w_done) begin ok = 1; break; end
      end
      aw_valid = 1'b0;
      w_valid  = 1'b0;
   endtask

   task automatic b_accept();
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
   endtask

   // ok reports that r_valid was up exactly one cycle after the AR handshake.
   task automatic do_read(input logic [31:0] addr, input logic [3:0] id, output bit ok,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [3:0] rid, output logic last);
      ok = 0; data = '0; resp = '0; rid = '0; last = 1'b0;
      ar_valid = 1'b1; ar_addr = addr; ar_id = id;
      for (int i = 0; i < 20; i++) begin
         if (ar_ready) begin
            tick();
            ar_valid = 1'b0;
            ok = r_valid; data = r_data; resp = r_resp; rid = r_id; last = r_last;
            r_ready = 1'b1;
            tick();
            r_ready = 1'b0;
            break;
         end
         tick();
      end
      ar_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
         failures++;
         $display("FAIL reset_readies: got %b expected 000", {aw_ready, w_ready, ar_ready});
      end
      checks++;
      if ({b_valid, r_valid, char_valid, r_last} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_valids: got %b expected 0000", {b_valid, r_valid, char_valid, r_last});
      end
      checks++;
      if ({err_code, err_valid, b_resp, r_data} !== 43'd0) begin
         failures++;
         $display("FAIL reset_data: err_code %h err_valid %b b_resp %b r_data %h expected all 0",
                  err_code, err_valid, b_resp, r_data);
      end
      @(posedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_release: readies %b expected 111", {aw_ready, w_ready, ar_ready});
      end
      tick();
   endtask

   task automatic test_hello();
      logic [7:0] hi [3];
      bit ok;
      hi = '{8'h48, 8'h69, 8'h0A};
      char_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send_wr(BASE + 32'd4, 4'd3, hi[k], 4'hF, 8'd0, 1'b1, ok);
         checks++;
         if (!ok || b_valid !== 1'b0 || char_valid !== 1'b0) begin
            failures++;
            $display("FAIL hello_early[%0d]: hs %0b b_valid %b char_valid %b expected 1 0 0",
                     k, ok, b_valid, char_valid);
         end
         tick();
         checks++;
         if (b_valid !== 1'b1 || b_resp !== 2'b00 || b_id !== 4'd3) begin
            failures++;
            $display("FAIL hello_b[%0d]: valid %b resp %b id %0d expected 1 00 3",
                     k, b_valid, b_resp, b_id);
         end
         checks++;
         if (char_valid !== 1'b1 || char_data !== hi[k] || char_id !== 4'd3 ||
             char_eol !== (hi[k] == 8'h0A)) begin
            failures++;
            $display("FAIL hello_char[%0d]: valid %b data %h id %0d eol %b expected 1 %h 3 %b",
                     k, char_valid, char_data, char_id, char_eol, hi[k], hi[k] == 8'h0A);
         end
         b_accept();
      end
      char_ready = 1'b0;
   endtask

   task automatic test_stderr();
      logic [1:0] exp_resp;
      logic [7:0] exp_code;
      logic       exp_ev;
      bit         ok;
      logic [31:0] d;
      logic [1:0] rr;
      logic [3:0] rid;
      logic       rl;
`ifdef MAGIA_PRINT_RSP_STDERR_EN
      exp_resp = 2'b00; exp_code = 8'h05; exp_ev = 1'b1;
`else
      exp_resp = 2'b10; exp_code = 8'h00; exp_ev = 1'b0;
`endif
      w_valid = 1'b1; w_data = 32'h0000_0005; w_strb = 4'hF; w_last = 1'b1;
      tick();
      w_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (aw_ready !== 1'b1 || w_ready !== 1'b0 || b_valid !== 1'b0) begin
         failures++;
         $display("FAIL stderr_wait: aw_ready %b w_ready %b b_valid %b expected 1 0 0",
                  aw_ready, w_ready, b_valid);
      end
      aw_valid = 1'b1; aw_addr = BASE; aw_id = 4'd6; aw_len = 8'd0;
      tick();
      aw_valid = 1'b0;
      checks++;
      if (b_valid !== 1'b0) begin
         failures++;
         $display("FAIL stderr_b_early: b_valid %b expected 0", b_valid);
      end
      tick();
      checks++;
      if (b_valid !== 1'b1 || b_resp !== exp_resp || b_id !== 4'd6) begin
         failures++;
         $display("FAIL stderr_b: valid %b resp %b id %0d expected 1 %b 6",
                  b_valid, b_resp, b_id, exp_resp);
      end
      checks++;
      if (err_code !== exp_code || err_valid !== exp_ev) begin
         failures++;
         $display("FAIL stderr_latch: code %h valid %b expected %h %b",
                  err_code, err_valid, exp_code, exp_ev);
      end
      b_accept();
      do_read(BASE, 4'd2, ok, d, rr, rid, rl);
      checks++;
      if (!ok || d !== {24'h0, exp_code} || rr !== exp_resp || rid !== 4'd2 || rl !== 1'b1) begin
         failures++;
         $display("FAIL stderr_read: valid %0b data %h resp %b id %0d last %b expected 1 %h %b 2 1",
                  ok, d, rr, rid, rl, exp_code, exp_resp);
      end
      checks++;
      if (char_valid !== 1'b0) begin
         failures++;
         $display("FAIL stderr_nochar: char_valid %b expected 0", char_valid);
      end
   endtask

   task automatic test_full();
      int nok, errs;
      bit ok, seen;
      logic [31:0] d;
      logic [1:0] rr;
      logic [3:0] rid;
      logic       rl;
      char_ready = 1'b0;
      nok = 0;
      for (int i = 0; i < 16; i++) begin
         send_wr(BASE + 32'd4, 4'(i), 8'h41 + 8'(i), 4'hF, 8'd0, 1'b1, ok);
         tick();
         if (ok && b_valid === 1'b1 && b_resp === 2'b00 && b_id === 4'(i)) nok++;
         b_accept();
      end
      checks++;
      if (nok != 16) begin
         failures++;
         $display("FAIL full_oks: good responses %0d expected 16", nok);
      end
      send_wr(BASE + 32'd4, 4'd0, 8'h51, 4'hF, 8'd0, 1'b1, ok);
      seen = 0;
      repeat (5) begin
         tick();
         if (b_valid !== 1'b0) seen = 1;
      end
      checks++;
      if (!ok || seen) begin
         failures++;
         $display("FAIL full_withheld: hs %0b b seen %0b expected 1 0", ok, seen);
      end
      do_read(BASE + 32'd4, 4'd1, ok, d, rr, rid, rl);
      checks++;
      if (!ok || d !== 32'd0 || rr !== 2'b00 || b_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_free: valid %0b free %0d resp %b b_valid %b expected 1 0 00 0",
                  ok, d, rr, b_valid);
      end
      checks++;
      if (char_valid !== 1'b1 || char_data !== 8'h41 || char_id !== 4'd0) begin
         failures++;
         $display("FAIL full_head: valid %b data %h id %0d expected 1 41 0",
                  char_valid, char_data, char_id);
      end
      char_ready = 1'b1;
      tick();
      char_ready = 1'b0;
      checks++;
      if (b_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_b_early: b_valid %b expected 0", b_valid);
      end
      tick();
      checks++;
      if (b_valid !== 1'b1 || b_resp !== 2'b00 || b_id !== 4'd0) begin
         failures++;
         $display("FAIL full_b_late: valid %b resp %b id %0d expected 1 00 0",
                  b_valid, b_resp, b_id);
      end
      b_accept();
      do_read(BASE + 32'd4, 4'd1, ok, d, rr, rid, rl);
      checks++;
      if (!ok || d !== 32'd0 || rr !== 2'b00) begin
         failures++;
         $display("FAIL full_free_after: valid %0b free %0d resp %b expected 1 0 00", ok, d, rr);
      end
      errs = 0;
      char_ready = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         if (char_valid !== 1'b1 || char_data !== 8'h41 + 8'(j) || char_id !== 4'(j)) begin
            errs++;
         end
         tick();
      end
      char_ready = 1'b0;
      checks++;
      if (errs != 0 || char_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_drain: order errors %0d char_valid %b expected 0 0", errs, char_valid);
      end
   endtask

   task automatic test_errors();
      logic [31:0] ea [4];
      logic [3:0]  es [4];
      logic [7:0]  el [4];
      logic        et [4];
      int          nerr;
      bit          ok;
      logic [31:0] d;
      logic [1:0]  rr;
      logic [3:0]  rid;
      logic        rl;
      ea = '{BASE + 32'd8, BASE + 32'd4, BASE + 32'd4, BASE + 32'd4};
      es = '{4'hF, 4'hF, 4'b0010, 4'hF};
      el = '{8'd0, 8'd1, 8'd0, 8'd0};
      et = '{1'b1, 1'b1, 1'b1, 1'b0};
      char_ready = 1'b0;
      nerr = 0;
      for (int i = 0; i < 4; i++) begin
         send_wr(ea[i], 4'd7, 8'h33, es[i], el[i], et[i], ok);
         tick();
         if (ok && b_valid === 1'b1 && b_resp === 2'b10 && b_id === 4'd7) nerr++;
         b_accept();
      end
      checks++;
      if (nerr != 4) begin
         failures++;
         $display("FAIL err_slverr: SLVERR responses %0d expected 4", nerr);
      end
      checks++;
      if (char_valid !== 1'b0) begin
         failures++;
         $display("FAIL err_nopush: char_valid %b expected 0", char_valid);
      end
      do_read(BASE + 32'd4, 4'd4, ok, d, rr, rid, rl);
      checks++;
      if (!ok || d !== 32'd16 || rr !== 2'b00 || rid !== 4'd4 || rl !== 1'b1) begin
         failures++;
         $display("FAIL err_free: valid %0b free %0d resp %b id %0d last %b expected 1 16 00 4 1",
                  ok, d, rr, rid, rl);
      end
      do_read(BASE + 32'd8, 4'd5, ok, d, rr, rid, rl);
      checks++;
      if (!ok || d !== 32'd0 || rr !== 2'b10 || rid !== 4'd5) begin
         failures++;
         $display("FAIL err_read: valid %0b data %h resp %b id %0d expected 1 0 10 5",
                  ok, d, rr, rid);
      end
   endtask

   task automatic test_wrap();
      logic [11:0] q [$];
      int          errs, nfree;
      bit          ok;
      logic [31:0] d;
      logic [1:0]  rr;
      logic [3:0]  rid;
      logic        rl;
      char_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_wr(BASE + 32'd4, 4'(k), 8'h60 + 8'(k), 4'hF, 8'd0, 1'b1, ok);
         tick();
         b_accept();
         q.push_back({4'(k), 8'h60 + 8'(k)});
      end
      errs = 0; nfree = 0;
      for (int i = 0; i < 15; i++) begin
         send_wr(BASE + 32'd4, 4'(i + 5), 8'h70 + 8'(i), 4'hF, 8'd0, 1'b1, ok);
         // In WRITE now: the push and this pop commit on the same edge.
         if (!ok || char_valid !== 1'b1 || {char_id, char_data} !== q[0]) errs++;
         char_ready = 1'b1;
         tick();
         char_ready = 1'b0;
         void'(q.pop_front());
         q.push_back({4'(i + 5), 8'h70 + 8'(i)});
         if (b_valid !== 1'b1 || b_resp !== 2'b00) errs++;
         b_accept();
         do_read(BASE + 32'd4, 4'd0, ok, d, rr, rid, rl);
         if (ok && d === 32'd11) nfree++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL wrap_order: errors %0d expected 0", errs);
      end
      checks++;
      if (nfree != 15) begin
         failures++;
         $display("FAIL wrap_count: reads of free=11 %0d expected 15", nfree);
      end
      errs = 0;
      char_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         if (char_valid !== 1'b1 || {char_id, char_data} !== q[j]) errs++;
         tick();
      end
      char_ready = 1'b0;
      checks++;
      if (errs != 0 || char_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_drain: errors %0d char_valid %b expected 0 0", errs, char_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit          ok;
      logic [31:0] d;
      logic [1:0]  rr;
      logic [3:0]  rid;
      logic        rl;
      char_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send_wr(BASE + 32'd4, 4'd1, 8'h30 + 8'(k), 4'hF, 8'd0, 1'b1, ok);
         tick();
         b_accept();
      end
      send_wr(BASE + 32'd4, 4'd1, 8'h33, 4'hF, 8'd0, 1'b1, ok);
      tick();
      checks++;
      if (b_valid !== 1'b1 || char_valid !== 1'b1 || char_data !== 8'h30) begin
         failures++;
         $display("FAIL rstmid_pre: b_valid %b char_valid %b head %h expected 1 1 30",
                  b_valid, char_valid, char_data);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (b_valid !== 1'b0 || char_valid !== 1'b0 || aw_ready !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_drop: b_valid %b char_valid %b aw_ready %b expected 0 0 0",
                  b_valid, char_valid, aw_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
         failures++;
         $display("FAIL rstmid_ready: readies %b expected 111", {aw_ready, w_ready, ar_ready});
      end
      send_wr(BASE + 32'd4, 4'd9, 8'h7A, 4'hF, 8'd0, 1'b1, ok);
      tick();
      checks++;
      if (!ok || b_valid !== 1'b1 || b_resp !== 2'b00 || b_id !== 4'd9 ||
          char_valid !== 1'b1 || char_data !== 8'h7A || char_id !== 4'd9) begin
         failures++;
         $display("FAIL rstmid_new: b %b/%b/%0d char %b/%h/%0d expected 1/00/9 1/7a/9",
                  b_valid, b_resp, b_id, char_valid, char_data, char_id);
      end
      b_accept();
      do_read(BASE + 32'd4, 4'd0, ok, d, rr, rid, rl);
      checks++;
      if (!ok || d !== 32'd15) begin
         failures++;
         $display("FAIL rstmid_free: valid %0b free %0d expected 1 15", ok, d);
      end
   endtask

   initial begin
      rst = 1'b1;
      aw_valid = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0;
      w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
      b_ready = 1'b0;
      ar_valid = 1'b0; ar_addr = '0; ar_id = '0;
      r_ready = 1'b0;
      char_ready = 1'b0;
      test_reset();
      test_hello();
      test_stderr();
      test_full();
      test_errors();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
